// File: rtl/mem_arb.sv
// Two-requester round-robin arbiter onto a shared memory-crossbar port.
// Optional MEM_ARB_LOCK_EN adds i_m0_lock/i_m1_lock to hold ownership across accesses.
module mem_arb #(
    parameter int READ_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef MEM_ARB_LOCK_EN
    input  logic        i_m0_lock,
    input  logic        i_m1_lock,
`endif
    input  logic        i_m0_req,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic        i_m0_wren,
    input  logic [3:0]  i_m0_mask,
    input  logic        i_m1_req,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic        i_m1_wren,
    input  logic [3:0]  i_m1_mask,
    output logic        o_m0_gnt,
    output logic        o_m1_gnt,
    output logic        o_m0_rvalid,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic [31:0] o_m1_rdata,
    output logic [29:0] o_addr,
    output logic [31:0] o_data,
    output logic        o_wren,
    output logic [3:0]  o_mask,
    input  logic [31:0] i_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] LP_CNT_INIT = 2'(READ_LAT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last, w_last_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic        w_any, w_rr_win, w_win;
    logic        w_own_wren;
    logic [3:0]  w_own_mask;
`ifdef MEM_ARB_LOCK_EN
    logic        r_lock, w_lock_nxt;
    logic        w_own_req, w_own_lock, w_hold;
`endif

    always_comb begin
        w_any    = i_m0_req | i_m1_req;
        // Single requester wins outright; on a tie the one not granted last time wins.
        w_rr_win = (i_m0_req & i_m1_req) ? ~r_last : i_m1_req;
`ifdef MEM_ARB_LOCK_EN
        w_own_req  = r_owner ? i_m1_req  : i_m0_req;
        w_own_lock = r_owner ? i_m1_lock : i_m0_lock;
        w_hold     = r_lock & w_own_req & w_own_lock;
        w_win      = w_hold ? r_owner : w_rr_win;
`else
        w_win      = w_rr_win;
`endif
    end

    always_comb begin
        o_addr     = r_owner ? i_m1_addr : i_m0_addr;
        o_data     = r_owner ? i_m1_data : i_m0_data;
        w_own_wren = r_owner ? i_m1_wren : i_m0_wren;
        w_own_mask = r_owner ? i_m1_mask : i_m0_mask;
    end

    assign o_m0_rdata = i_data;
    assign o_m1_rdata = i_data;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
`ifdef MEM_ARB_LOCK_EN
        w_lock_nxt  = r_lock;
`endif
        o_m0_gnt    = 1'b0;
        o_m1_gnt    = 1'b0;
        o_m0_rvalid = 1'b0;
        o_m1_rvalid = 1'b0;
        o_wren      = 1'b0;
        o_mask      = 4'h0;
        case (r_state)
            IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                w_lock_nxt = w_hold;
`endif
                if (w_any) begin
                    w_owner_nxt = w_win;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_wren     = w_own_wren;
                o_mask     = w_own_mask;
                o_m0_gnt   = ~r_owner;
                o_m1_gnt   = r_owner;
                w_last_nxt = r_owner;
`ifdef MEM_ARB_LOCK_EN
                w_lock_nxt = w_own_lock;
`endif
                if (w_own_wren) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = LP_CNT_INIT;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 2'd0) begin
                    o_m0_rvalid = ~r_owner;
                    o_m1_rvalid = r_owner;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 2'd0;
`ifdef MEM_ARB_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef MEM_ARB_LOCK_EN
            r_lock  <= w_lock_nxt;
`endif
        end
    end

endmodule
